pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage forwarding MIPS core.
- Decides each cycle whether PC, IF/ID and ID/EX advance, hold, or take a bubble.
- Handles three cases: load-use hazards (one-cycle stall), taken branches resolved in EX (flush IF/ID and ID/EX), and multi-cycle mult/div in EX (hold front end and EX for MD_LAT cycles).
- Keeps stall and flush performance counters.

Parameters:
MD_LAT, 4, total stall cycles per mult/div; legal range 2..15
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_id  in  5  rs field of instruction in ID
rt_id  in  5  rt field of instruction in ID
uses_rs_id  in  1  ID instruction reads rs
uses_rt_id  in  1  ID instruction reads rt
MemRead_inIDEX  in  3  ID/EX MemRead control; nonzero means a load is in EX
rt_inIDEX  in  5  destination rt of the instruction in EX
branch_taken_ex  in  1  branch/jump in EX resolved taken
md_start_ex  in  1  mult/div instruction present in EX
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID loads a NOP
idex_we  out  1  ID/EX write enable
idex_flush  out  1  ID/EX loads all-zero controls (bubble)
exmem_bubble  out  1  EX/MEM loads a bubble; EX is holding
md_busy  out  1  state == MD_BUSY
md_done  out  1  one-cycle pulse on the first cycle after a mult/div stall ends
stall_cycles  out  CNT_W  count of cycles with pc_we==0, saturating
flush_count  out  CNT_W  count of taken-branch flushes, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RUN, md_cnt = 0, ack_r = 0, both counters = 0.
  - While rst_n is low, outputs are forced to: pc_we = ifid_we = idex_we = 0, ifid_flush = idex_flush = 1, exmem_bubble = md_busy = md_done = 0.
  - Reset mid-stall abandons the stall; after release the block is in RUN.
- load_use = (MemRead_inIDEX != 0) && (rt_inIDEX != 0) && ((uses_rs_id && rs_id == rt_inIDEX) || (uses_rt_id && rt_id == rt_inIDEX)). Register $0 never creates a hazard.
- Default outputs in RUN: pc_we = ifid_we = idex_we = 1; all flush/bubble outputs = 0.
- RUN, priority 1: branch_taken_ex.
  - ifid_flush = 1, idex_flush = 1, pc_we = 1.
  - Overrides load_use in the same cycle (the ID instruction is squashed anyway).
  - flush_count += 1.
- RUN, priority 2: md_start_ex && !ack_r.
  - pc_we = ifid_we = idex_we = 0, exmem_bubble = 1.
  - md_cnt <= MD_LAT-1; next state MD_BUSY.
- RUN, priority 3: load_use.
  - pc_we = ifid_we = 0, idex_flush = 1; idex_we stays 1.
  - No state change. The hazard clears itself next cycle because the bubble has MemRead = 0.
- MD_BUSY:
  - pc_we = ifid_we = idex_we = 0, exmem_bubble = 1, md_busy = 1.
  - branch_taken_ex and load_use are ignored.
  - md_cnt decrements each cycle. When md_cnt == 1: next state RUN, ack_r <= 1.
- ack_r:
  - Cleared on any RUN cycle.
  - md_done = ack_r && state == RUN.
  - While ack_r is set, md_start_ex is ignored so the same mult/div does not retrigger. Load_use/branch still apply that cycle.
- Timing:
  - Total stall per mult/div = MD_LAT cycles: 1 in RUN plus MD_LAT-1 in MD_BUSY.
  - The EX instruction advances on the cycle md_done is high.
- Counters:
  - stall_cycles increments every cycle pc_we == 0 (reset excluded).
  - Both counters saturate at all-ones and never wrap.
- All control outputs are combinational from state, ack_r and the inputs. Only state, md_cnt, ack_r and the counters are registered.

Test Plan:
- Load-use: EX lw with MemRead=3'b001, rt_inIDEX=8; ID uses_rs_id=1, rs_id=8 -> one cycle of pc_we=0, ifid_we=0, idex_flush=1; next cycle (MemRead=0) all enables 1; stall_cycles=1.
- Zero register: same as above but rt_inIDEX=0, rs_id=0 -> no stall, pc_we=1.
- Branch over hazard: branch_taken_ex=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_we=1; flush_count=1, stall_cycles unchanged.
- Mult/div with MD_LAT=4: md_start_ex held high -> pc_we=0 and exmem_bubble=1 for exactly 4 cycles, md_busy high for cycles 2-4, md_done pulse on cycle 5, no retrigger; stall_cycles=4.
- Branch during MD_BUSY: branch_taken_ex=1 -> ignored, ifid_flush=0, flush_count unchanged.
- Reset mid-stall: rst_n low at MD_BUSY cycle 2 -> outputs immediately take the reset values, counters 0; after release, state RUN with pc_we=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage forwarding MIPS core:
// load-use stalls, taken-branch flushes, multi-cycle mult/div holds, perf counters.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic [2:0]       MemRead_inIDEX,
    input  logic [4:0]       rt_inIDEX,
    input  logic             branch_taken_ex,
    input  logic             md_start_ex,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [3:0] MD_LAT_M1 = 4'(MD_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       ack_r, ack_nxt;
    logic       load_use;
    logic       flush_inc;

    assign load_use = (MemRead_inIDEX != 3'd0) && (rt_inIDEX != 5'd0) &&
                      ((uses_rs_id && (rs_id == rt_inIDEX)) ||
                       (uses_rt_id && (rt_id == rt_inIDEX)));

    assign flush_inc = (state == RUN) && branch_taken_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            md_cnt       <= '0;
            ack_r        <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            ack_r  <= ack_nxt;
            if (!pc_we && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

    // ack_r suppresses a retrigger by the same mult/div still sitting in EX
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        ack_nxt    = 1'b0;
        case (state)
            RUN: begin
                if (!branch_taken_ex && md_start_ex && !ack_r) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = MD_LAT_M1;
                end
            end
            MD_BUSY: begin
                md_cnt_nxt = md_cnt - 4'd1;
                if (md_cnt == 4'd1) begin
                    state_nxt = RUN;
                    ack_nxt   = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (!rst_n) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    md_done = ack_r;
                    if (branch_taken_ex) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (md_start_ex && !ack_r) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_we      = 1'b0;
                        exmem_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    md_busy      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
